// File: rtl/uart_morse_dispatcher.sv
// ============================================================================
// Module      : uart_morse_dispatcher
// Description : Queues received UART bytes and hands them one at a time to a
//               morse generator, with display history, gap and timeout control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_morse_dispatcher #(
    parameter int WORD_BITS      = 8,
    parameter int FIFO_ADDR_BITS = 3,
    parameter int HIST_BYTES     = 2,
    parameter int GAP_CYCLES     = 60_000_000,
    parameter int TIMEOUT_CYCLES = 200_000_000,
    parameter int FILTER_CTRL    = 1
) (
    input  logic                             clk_i,
    input  logic                             reset_ni,
    input  logic [WORD_BITS-1:0]             rx_data_i,
    input  logic                             rx_done_i,
    input  logic                             morse_done_i,
    input  logic                             mode_i,
    input  logic                             clear_i,
    output logic [WORD_BITS-1:0]             morse_ascii_o,
    output logic                             morse_en_o,
    output logic [HIST_BYTES*WORD_BITS-1:0]  hist_o,
    output logic [FIFO_ADDR_BITS:0]          fifo_count_o,
    output logic                             busy_o,
    output logic                             overflow_o,
    output logic                             timeout_o
);

    localparam int c_DEPTH  = 2**FIFO_ADDR_BITS;
    localparam int c_HIST_W = HIST_BYTES*WORD_BITS;
    localparam int c_TMAX   = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int c_TW     = (c_TMAX > 2) ? $clog2(c_TMAX) : 1;

    localparam logic [FIFO_ADDR_BITS:0] c_FULL     = (FIFO_ADDR_BITS+1)'(c_DEPTH);
    localparam logic [c_TW-1:0]         c_TO_LAST  = c_TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES-1 : 0);
    localparam logic [c_TW-1:0]         c_GAP_LAST = c_TW'((GAP_CYCLES > 0) ? GAP_CYCLES-1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t                      r_state;
    logic [c_TW-1:0]             r_timer;
    logic [WORD_BITS-1:0]        r_ascii;
    logic                        r_en;
    logic                        r_timeout;
    logic                        r_overflow;
    logic [c_HIST_W-1:0]         r_hist;
    logic [WORD_BITS-1:0]        r_mem [c_DEPTH];
    logic [FIFO_ADDR_BITS-1:0]   r_wr_ptr;
    logic [FIFO_ADDR_BITS-1:0]   r_rd_ptr;
    logic [FIFO_ADDR_BITS:0]     r_count;

    logic w_is_ctrl;
    logic w_push_req;
    logic w_full;
    logic w_pop;
    logic w_push_ok;

    assign w_is_ctrl  = (rx_data_i < WORD_BITS'(32)) || (rx_data_i == WORD_BITS'(127));
    assign w_push_req = rx_done_i && !mode_i && !((FILTER_CTRL != 0) && w_is_ctrl) && !clear_i;
    assign w_full     = (r_count == c_FULL);
    assign w_pop      = (r_state == S_IDLE) && (r_count != '0) && !clear_i;
    // A full queue still accepts a byte when the head leaves on the same edge.
    assign w_push_ok  = w_push_req && (!w_full || w_pop);

    always_ff @(posedge clk_i) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= rx_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (clear_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + FIFO_ADDR_BITS'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_ADDR_BITS'(1);
            end
            if (w_push_req && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + (FIFO_ADDR_BITS+1)'(1);
            end else if (w_pop && !w_push_ok) begin
                r_count <= r_count - (FIFO_ADDR_BITS+1)'(1);
            end
        end
    end

    // History follows every received byte, independent of mode and filtering.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_hist <= '0;
        end else if (clear_i) begin
            r_hist <= '0;
        end else if (rx_done_i) begin
            r_hist <= (r_hist << WORD_BITS) | c_HIST_W'(rx_data_i);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_ascii   <= '0;
            r_en      <= 1'b0;
            r_timeout <= 1'b0;
        end else if (clear_i) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_en      <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_ascii <= r_mem[r_rd_ptr];
                        r_en    <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_timer <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (morse_done_i || (r_timer == c_TO_LAST)) begin
                        if (!morse_done_i) begin
                            r_timeout <= 1'b1;
                        end
                        r_timer <= '0;
                        r_state <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                    end else begin
                        r_timer <= r_timer + c_TW'(1);
                    end
                end
                S_GAP: begin
                    if (r_timer == c_GAP_LAST) begin
                        r_timer <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + c_TW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign morse_ascii_o = r_ascii;
    assign morse_en_o    = r_en;
    assign hist_o        = r_hist;
    assign fifo_count_o  = r_count;
    assign busy_o        = (r_state != S_IDLE);
    assign overflow_o    = r_overflow;
    assign timeout_o     = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_uart_morse_dispatcher.sv
// ============================================================================
// Module      : tb_uart_morse_dispatcher
// Description : Scoreboard bench for uart_morse_dispatcher (small queue, short
//               gap and timeout).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_morse_dispatcher;

    logic        clk;
    logic        reset_ni;
    logic [7:0]  rx_data_i;
    logic        rx_done_i;
    logic        morse_done_i;
    logic        mode_i;
    logic        clear_i;
    logic [7:0]  morse_ascii_o;
    logic        morse_en_o;
    logic [15:0] hist_o;
    logic [2:0]  fifo_count_o;
    logic        busy_o;
    logic        overflow_o;
    logic        timeout_o;

    int n_tests = 0;
    int n_fail  = 0;
    int n_en    = 0;
    int en_mark;
    logic [7:0] exp_q[$];

    uart_morse_dispatcher #(
        .WORD_BITS      (8),
        .FIFO_ADDR_BITS (2),
        .HIST_BYTES     (2),
        .GAP_CYCLES     (4),
        .TIMEOUT_CYCLES (16),
        .FILTER_CTRL    (1)
    ) u_dut (
        .clk_i         (clk),
        .reset_ni      (reset_ni),
        .rx_data_i     (rx_data_i),
        .rx_done_i     (rx_done_i),
        .morse_done_i  (morse_done_i),
        .mode_i        (mode_i),
        .clear_i       (clear_i),
        .morse_ascii_o (morse_ascii_o),
        .morse_en_o    (morse_en_o),
        .hist_o        (hist_o),
        .fifo_count_o  (fifo_count_o),
        .busy_o        (busy_o),
        .overflow_o    (overflow_o),
        .timeout_o     (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic m, input bit queued);
        rx_data_i = b;
        mode_i    = m;
        rx_done_i = 1'b1;
        if (queued) exp_q.push_back(b);
        tick();
        rx_done_i = 1'b0;
        mode_i    = 1'b0;
    endtask

    task automatic wait_en(input int budget);
        int k = 0;
        while (!morse_en_o && k < budget) begin
            tick();
            k++;
        end
        check("en_wait", morse_en_o, 1);
    endtask

    task automatic pulse_done();
        morse_done_i = 1'b1;
        tick();
        morse_done_i = 1'b0;
    endtask

    // Every start strobe must match the oldest character still expected.
    always @(negedge clk) begin
        if (reset_ni && morse_en_o) begin
            n_en++;
            if (exp_q.size() == 0) check("unexp_en", exp_q.size(), 1);
            else                   check("char", morse_ascii_o, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_ni = 1'b0; rx_data_i = '0; rx_done_i = 1'b0;
        morse_done_i = 1'b0; mode_i = 1'b0; clear_i = 1'b0;
        repeat (3) tick();
        check("rst_en",    morse_en_o, 0);
        check("rst_ascii", morse_ascii_o, 0);
        check("rst_busy",  busy_o, 0);
        check("rst_count", fifo_count_o, 0);
        check("rst_hist",  hist_o, 0);
        check("rst_ovf",   overflow_o, 0);
        check("rst_to",    timeout_o, 0);
        reset_ni = 1'b1;
        repeat (2) tick();

        // Single byte: start strobe two cycles after the receive strobe.
        send(8'h41, 1'b0, 1'b1);
        check("single_cnt",  fifo_count_o, 1);
        check("single_n1_en", morse_en_o, 0);
        tick();
        check("single_en",    morse_en_o, 1);
        check("single_ascii", morse_ascii_o, 8'h41);
        check("single_busy",  busy_o, 1);
        tick();
        check("single_en_1cyc", morse_en_o, 0);
        repeat (4) tick();
        pulse_done();
        repeat (3) tick();
        check("gap_busy", busy_o, 1);
        tick();
        check("gap_idle", busy_o, 0);
        check("single_hold", morse_ascii_o, 8'h41);

        // Overflow: five bytes while the first one is waiting on the generator.
        send(8'h30, 1'b0, 1'b1);
        repeat (2) tick();
        for (int i = 1; i <= 5; i++) send(8'(8'h30 + i), 1'b0, i <= 4);
        check("ovf_count", fifo_count_o, 4);
        check("ovf_flag",  overflow_o, 1);
        pulse_done();
        for (int i = 0; i < 4; i++) begin
            wait_en(20);
            tick();
            pulse_done();
        end
        repeat (6) tick();
        check("ovf_drain", fifo_count_o, 0);
        check("ovf_idle",  busy_o, 0);

        // Filter and display-only mode.
        en_mark = n_en;
        send(8'h0D, 1'b0, 1'b0);
        send(8'h42, 1'b1, 1'b0);
        repeat (6) tick();
        check("filt_no_en", n_en - en_mark, 0);
        check("filt_hist",  hist_o, 16'h0D42);
        check("filt_count", fifo_count_o, 0);
        send(8'h7F, 1'b0, 1'b0);
        send(8'h20, 1'b0, 1'b1);
        wait_en(10);
        tick();
        pulse_done();
        repeat (6) tick();
        check("filt_edge_count", fifo_count_o, 0);

        // Timeout after 16 cycles in WAIT.
        send(8'h45, 1'b0, 1'b1);
        wait_en(10);
        tick();
        repeat (15) tick();
        check("to_early", timeout_o, 0);
        tick();
        check("to_set",  timeout_o, 1);
        check("to_busy", busy_o, 1);
        repeat (3) tick();
        check("to_gap",  busy_o, 1);
        tick();
        check("to_idle", busy_o, 0);

        // Clear with a byte in flight and two queued.
        send(8'h50, 1'b0, 1'b1);
        wait_en(10);
        send(8'h51, 1'b0, 1'b0);
        send(8'h52, 1'b0, 1'b0);
        check("clr_pre_count", fifo_count_o, 2);
        check("clr_pre_ovf",   overflow_o, 1);
        rx_data_i = 8'h46; rx_done_i = 1'b1; clear_i = 1'b1;
        tick();
        rx_done_i = 1'b0; clear_i = 1'b0;
        check("clr_count", fifo_count_o, 0);
        check("clr_hist",  hist_o, 0);
        check("clr_ovf",   overflow_o, 0);
        check("clr_to",    timeout_o, 0);
        check("clr_busy",  busy_o, 0);
        en_mark = n_en;
        pulse_done();
        repeat (10) tick();
        check("clr_no_en", n_en - en_mark, 0);

        // Reset in the middle of GAP abandons the character.
        send(8'h60, 1'b0, 1'b1);
        wait_en(10);
        tick();
        pulse_done();
        tick();
        check("pre_rst_busy", busy_o, 1);
        reset_ni = 1'b0;
        #1;
        check("mid_rst_busy",  busy_o, 0);
        check("mid_rst_count", fifo_count_o, 0);
        check("mid_rst_hist",  hist_o, 0);
        check("mid_rst_ascii", morse_ascii_o, 0);
        check("mid_rst_en",    morse_en_o, 0);
        tick();
        reset_ni = 1'b1;
        en_mark = n_en;
        repeat (10) tick();
        check("post_rst_no_en", n_en - en_mark, 0);
        send(8'h61, 1'b0, 1'b1);
        wait_en(10);
        check("post_rst_ascii", morse_ascii_o, 8'h61);
        tick();
        pulse_done();
        repeat (6) tick();

        check("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_morse_dispatcher.md
UART_MORSE_DISPATCHER -- requirements
Module: uart_morse_dispatcher

Interface
REQ-001 Parameter WORD_BITS, default 8: width of every character byte.
REQ-002 Parameter FIFO_ADDR_BITS, default 3: character queue depth is 2**FIFO_ADDR_BITS entries.
REQ-003 Parameter HIST_BYTES, default 2: number of most-recent received bytes exported for display.
REQ-004 Parameter GAP_CYCLES, default 60_000_000: idle clocks between consecutive characters, where 0 means no gap.
REQ-005 Parameter TIMEOUT_CYCLES, default 200_000_000: maximum clocks to wait for generator completion.
REQ-006 Parameter FILTER_CTRL, default 1: when 1, bytes below 0x20 and byte 0x7F are not queued.
REQ-007 clk_i  in  1  system clock, single clock domain.
REQ-008 reset_ni  in  1  asynchronous, active-low reset.
REQ-009 rx_data_i  in  WORD_BITS  received byte, valid while rx_done_i is high.
REQ-010 rx_done_i  in  1  one-cycle strobe marking a received byte.
REQ-011 morse_done_i  in  1  one-cycle strobe from the generator marking character completion.
REQ-012 mode_i  in  1  0 = queue for morse, 1 = display-only (nothing queued).
REQ-013 clear_i  in  1  synchronous flush request.
REQ-014 morse_ascii_o  out  WORD_BITS  character presented to the generator.
REQ-015 morse_en_o  out  1  one-cycle start strobe to the generator.
REQ-016 hist_o  out  HIST_BYTES*WORD_BITS  history of bytes, with the newest in the least-significant byte.
REQ-017 fifo_count_o  out  FIFO_ADDR_BITS+1  current queue occupancy.
REQ-018 busy_o  out  1  high in any FSM state other than IDLE.
REQ-019 overflow_o  out  1  sticky flag: a byte was dropped because the queue was full.
REQ-020 timeout_o  out  1  sticky flag: the generator failed to report done in time.

Function
REQ-021 The queue SHALL push rx_data_i on rx_done_i only when mode_i=0 and the byte is not filtered.
- Filtering per REQ-006.
REQ-022 A push with fifo_count_o = 2**FIFO_ADDR_BITS SHALL drop the byte, set overflow_o, and leave the queue unchanged.
- Exception: a pop in the same cycle, in which case both the push and the pop succeed and the count is unchanged.
REQ-023 Read and write pointers SHALL wrap modulo 2**FIFO_ADDR_BITS, and fifo_count_o SHALL saturate at neither end.
- No pop occurs when the queue is empty.
REQ-024 On every rx_done_i, regardless of mode_i or filtering, hist_o SHALL shift left by WORD_BITS and load rx_data_i into bits [WORD_BITS-1:0].
REQ-025 The FSM SHALL have exactly the states IDLE, ISSUE, WAIT and GAP.
REQ-026 IDLE: when fifo_count_o is nonzero, pop the head into morse_ascii_o and go to ISSUE.
REQ-027 ISSUE: morse_en_o high for exactly this one cycle, then go to WAIT.
REQ-028 WAIT: on morse_done_i, go to GAP.
- Otherwise, after TIMEOUT_CYCLES clocks in WAIT, set timeout_o and go to GAP.
REQ-029 GAP: stay GAP_CYCLES clocks, then go to IDLE.
- With GAP_CYCLES=0, WAIT goes directly to IDLE.
- morse_done_i outside WAIT is ignored.
REQ-030 morse_ascii_o SHALL hold stable from the pop until the next pop.
REQ-031 Latency: with the FSM in IDLE and the queue empty, rx_done_i in cycle n SHALL produce morse_en_o high in cycle n+2.
REQ-032 A change of mode_i SHALL affect only future pushes.
- A character in flight and the queued characters still complete.
REQ-033 clear_i SHALL, on the next edge:
- empty the queue;
- zero hist_o;
- clear overflow_o and timeout_o;
- return the FSM to IDLE with morse_en_o low.
- clear_i takes priority over a simultaneous rx_done_i, and that byte is discarded.

Reset
REQ-034 reset_ni low SHALL asynchronously force:
- FSM = IDLE;
- queue empty, fifo_count_o=0;
- morse_ascii_o=0, morse_en_o=0;
- hist_o=0;
- busy_o=0, overflow_o=0, timeout_o=0.
REQ-035 Reset asserted mid-WAIT or mid-GAP SHALL abandon the character.
- After release, no morse_en_o occurs until a new byte is received.

Verification
Bench parameters: FIFO_ADDR_BITS=2, HIST_BYTES=2, GAP_CYCLES=4, TIMEOUT_CYCLES=16.
REQ-036 Single byte: rx 0x41 in cycle n -> morse_en_o in cycle n+2 with morse_ascii_o=0x41; done after 5 cycles -> busy_o low 4 cycles after done.
REQ-037 Overflow: 6 back-to-back bytes 0x30..0x35 while the first is in WAIT -> fifo_count_o=4, overflow_o=1; characters emitted in order 0x30,0x31,0x32,0x33,0x34.
REQ-038 Filter/mode: rx 0x0D, then 0x42 with mode_i=1 -> no morse_en_o; hist_o=0x0D42.
REQ-039 Timeout: rx 0x45, no morse_done_i -> timeout_o set 16 cycles after entering WAIT, FSM returns to IDLE after GAP.
REQ-040 Clear/reset: clear_i coincident with rx 0x46 while 2 bytes are queued -> count 0, hist_o 0, no morse_en_o; reset_ni pulsed mid-GAP -> all outputs at reset values.
